// File: rtl/miller_byte_deframer.sv
// Miller byte deframer: turns decoded bit strobes from the Miller decoder
// back into MSB-first bytes. It can optionally hunt for a sync word first,
// ends a frame after an idle timeout, and queues the bytes in a small FIFO.
// The FIFO drives a valid/ready output interface.
module miller_byte_deframer #(
  parameter int         SYNC_EN      = 0,
  parameter logic [7:0] SYNC_WORD    = 8'h7E,
  parameter int         IDLE_TIMEOUT = 64,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       Bit_in,
  input  logic       Bit_in_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_tready,
  output logic       frame_active,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IC_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [IC_W-1:0]   idle_cnt, idle_cnt_n;
  logic [7:0]        sr;
  logic [7:0]        nxt;
  logic              push;
  logic              frame_err_n;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, pop, push_ok;

  // The candidate shift-register value if a strobe arrives this cycle.
  assign nxt = {sr[6:0], Bit_in};

  // Next-state logic: framing FSM, bit counter, idle timeout and byte push.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    idle_cnt_n  = idle_cnt;
    push        = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        idle_cnt_n = '0;
        if (Bit_in_valid) begin
          if (SYNC_EN != 0) begin
            state_n   = ST_HUNT;
            bit_cnt_n = 3'd0;
          end else begin
            // The first bit after idle is already the MSB of a byte.
            state_n   = ST_DATA;
            bit_cnt_n = 3'd1;
          end
        end
      end
      ST_HUNT, ST_DATA: begin
        if (Bit_in_valid) begin
          // A strobe in the timeout cycle wins over the timeout.
          idle_cnt_n = '0;
          if (state == ST_HUNT) begin
            if (nxt == SYNC_WORD) begin
              state_n   = ST_DATA;
              bit_cnt_n = 3'd0;
            end
          end else begin
            push      = (bit_cnt == 3'd7);
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else if (idle_cnt == IC_W'(IDLE_TIMEOUT - 1)) begin
          state_n     = ST_IDLE;
          bit_cnt_n   = 3'd0;
          idle_cnt_n  = '0;
          frame_err_n = (state == ST_DATA) && (bit_cnt != 3'd0);
        end else begin
          idle_cnt_n = idle_cnt + IC_W'(1);
        end
      end
      default: begin
        state_n   = ST_IDLE;
        bit_cnt_n = 3'd0;
      end
    endcase
  end

  // Framing registers: state, counters, shift register and the error pulse.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      idle_cnt  <= '0;
      sr        <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      idle_cnt  <= idle_cnt_n;
      frame_err <= frame_err_n;
      if (Bit_in_valid) sr <= nxt;
    end
  end

  assign frame_active = (state != ST_IDLE);

  // FIFO control: a push and a pop on the same edge are both legal when the
  // FIFO is full.
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign data_out_valid = (count != '0);
  assign pop            = data_out_valid && data_out_tready;
  assign push_ok        = push && (!full || pop);

  // NOTE: the storage array has no reset, so it maps to plain RAM/registers.
  // data_out is forced to zero while the FIFO is empty, so stale contents
  // never become visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= nxt;
  end

  assign data_out = data_out_valid ? mem[rd_ptr] : 8'h00;

  // FIFO pointers, occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_miller_byte_deframer.sv
// Directed testbench for miller_byte_deframer. It uses one unaligned
// instance (u_dut) and one sync-hunting instance (u_sync). Both instances
// share the stimulus.
module tb_miller_byte_deframer;

  logic       clk = 1'b0;
  logic       rst_p;
  logic       Bit_in;
  logic       Bit_in_valid;
  logic       data_out_tready;

  logic [7:0] data_out,  s_data_out;
  logic       data_out_valid, s_data_out_valid;
  logic       frame_active,   s_frame_active;
  logic       frame_err,      s_frame_err;
  logic       overflow,       s_overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  miller_byte_deframer #(.SYNC_EN(0), .SYNC_WORD(8'h7E), .IDLE_TIMEOUT(64), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_p(rst_p), .Bit_in(Bit_in), .Bit_in_valid(Bit_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_tready(data_out_tready),
    .frame_active(frame_active), .frame_err(frame_err), .overflow(overflow)
  );

  miller_byte_deframer #(.SYNC_EN(1), .SYNC_WORD(8'h7E), .IDLE_TIMEOUT(64), .FIFO_DEPTH(4)) u_sync (
    .clk(clk), .rst_p(rst_p), .Bit_in(Bit_in), .Bit_in_valid(Bit_in_valid),
    .data_out(s_data_out), .data_out_valid(s_data_out_valid), .data_out_tready(data_out_tready),
    .frame_active(s_frame_active), .frame_err(s_frame_err), .overflow(s_overflow)
  );

  // Strobe one bit and return at the next negedge, just after the sampling edge.
  task automatic strobe(input logic b);
    Bit_in       = b;
    Bit_in_valid = 1'b1;
    @(negedge clk);
    Bit_in_valid = 1'b0;
    Bit_in       = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send a byte MSB first with one strobe every gap clocks. The task returns
  // just after the edge that samples the 8th bit.
  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      strobe(v[i]);
      if (i != 0) idle_cycles(gap - 1);
    end
  endtask

  task automatic do_reset();
    Bit_in          = 1'b0;
    Bit_in_valid    = 1'b0;
    data_out_tready = 1'b0;
    rst_p           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    Bit_in = 1'b0; Bit_in_valid = 1'b0; data_out_tready = 1'b1;
    rst_p = 1'b1;
    @(negedge clk);
    tests++;
    if ({data_out, data_out_valid, frame_active, frame_err, overflow} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h v=%b fa=%b fe=%b ov=%b, want all 0",
               data_out, data_out_valid, frame_active, frame_err, overflow);
    end
    rst_p = 1'b0;
    idle_cycles(2);
    tests++;
    if ({data_out_valid, frame_active, s_data_out_valid, s_frame_active} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_idle: got v=%b fa=%b sv=%b sfa=%b, want 0000",
               data_out_valid, frame_active, s_data_out_valid, s_frame_active);
    end
  endtask

  task automatic test_basic();
    do_reset();
    data_out_tready = 1'b1;
    send_byte(8'hA5, 4);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'hA5 || frame_active !== 1'b1) begin
      fails++;
      $display("FAIL basic_byte0: got v=%b data=%h fa=%b, want v=1 data=a5 fa=1",
               data_out_valid, data_out, frame_active);
    end
    idle_cycles(1);
    tests++;
    if (data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_pop0: got v=%b, want 0", data_out_valid);
    end
    idle_cycles(2);
    send_byte(8'h3C, 4);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h3C) begin
      fails++;
      $display("FAIL basic_byte1: got v=%b data=%h, want v=1 data=3c", data_out_valid, data_out);
    end
  endtask

  task automatic test_sync();
    do_reset();
    data_out_tready = 1'b1;
    send_byte(8'h00, 2);
    tests++;
    if (s_data_out_valid !== 1'b0 || s_frame_active !== 1'b1) begin
      fails++;
      $display("FAIL sync_hunt_00: got v=%b fa=%b, want v=0 fa=1", s_data_out_valid, s_frame_active);
    end
    idle_cycles(1);
    send_byte(8'h7E, 2);
    tests++;
    if (s_data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sync_word_not_delivered: got v=%b data=%h, want v=0", s_data_out_valid, s_data_out);
    end
    idle_cycles(1);
    send_byte(8'h81, 2);
    tests++;
    if (s_data_out_valid !== 1'b1 || s_data_out !== 8'h81) begin
      fails++;
      $display("FAIL sync_payload: got v=%b data=%h, want v=1 data=81", s_data_out_valid, s_data_out);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    data_out_tready = 1'b1;
    for (int i = 0; i < 5; i++) strobe(1'b1);
    idle_cycles(63);
    tests++;
    if (frame_err !== 1'b0 || frame_active !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: got fe=%b fa=%b, want fe=0 fa=1", frame_err, frame_active);
    end
    idle_cycles(1);
    tests++;
    if (frame_err !== 1'b1 || frame_active !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: got fe=%b fa=%b, want fe=1 fa=0", frame_err, frame_active);
    end
    idle_cycles(1);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse_width: got fe=%b, want 0", frame_err);
    end
    send_byte(8'hFF, 1);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'hFF) begin
      fails++;
      $display("FAIL timeout_fresh_byte: got v=%b data=%h, want v=1 data=ff", data_out_valid, data_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(exp[i], 1);
    tests++;
    if (overflow !== 1'b0 || data_out !== 8'h11) begin
      fails++;
      $display("FAIL ovf_full_no_flag: got ov=%b data=%h, want ov=0 data=11", overflow, data_out);
    end
    send_byte(8'h55, 1);
    idle_cycles(3);
    tests++;
    if (overflow !== 1'b1 || data_out_valid !== 1'b1 || data_out !== 8'h11) begin
      fails++;
      $display("FAIL ovf_flag_hold: got ov=%b v=%b data=%h, want ov=1 v=1 data=11",
               overflow, data_out_valid, data_out);
    end
    data_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (data_out_valid !== 1'b1 || data_out !== exp[i]) begin
        fails++;
        $display("FAIL ovf_drain_%0d: got v=%b data=%h, want v=1 data=%h", i, data_out_valid, data_out, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (data_out_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_empty_sticky: got v=%b ov=%b, want v=0 ov=1", data_out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] last;
    logic [7:0] exp [4];
    exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'h05;
    last = 8'h05;
    do_reset();
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    for (int i = 7; i >= 1; i--) strobe(last[i]);
    // The final bit strobe and the pop of 0x01 land on the same edge.
    Bit_in = last[0]; Bit_in_valid = 1'b1; data_out_tready = 1'b1;
    @(negedge clk);
    Bit_in_valid = 1'b0; data_out_tready = 1'b0;
    tests++;
    if (overflow !== 1'b0 || data_out_valid !== 1'b1 || data_out !== 8'h02) begin
      fails++;
      $display("FAIL b2b_push_pop_full: got ov=%b v=%b data=%h, want ov=0 v=1 data=02",
               overflow, data_out_valid, data_out);
    end
    data_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (data_out_valid !== 1'b1 || data_out !== exp[i]) begin
        fails++;
        $display("FAIL b2b_drain_%0d: got v=%b data=%h, want v=1 data=%h", i, data_out_valid, data_out, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_count4: got v=%b after 4 pops, want 0", data_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hC3, 1);
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    rst_p = 1'b1;
    #1;
    tests++;
    if ({data_out, data_out_valid, frame_active, frame_err, overflow} !== 12'h000) begin
      fails++;
      $display("FAIL midreset_outputs: got data=%h v=%b fa=%b fe=%b ov=%b, want all 0",
               data_out, data_out_valid, frame_active, frame_err, overflow);
    end
    @(negedge clk);
    rst_p = 1'b0;
    data_out_tready = 1'b1;
    @(negedge clk);
    send_byte(8'h5A, 2);
    tests++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h5A) begin
      fails++;
      $display("FAIL midreset_fresh_byte: got v=%b data=%h, want v=1 data=5a", data_out_valid, data_out);
    end
  endtask

  initial begin
    rst_p = 1'b1; Bit_in = 1'b0; Bit_in_valid = 1'b0; data_out_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sync();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
